// File: rtl/sync_fifo_ctrl_if.sv
// Stream and RAM-port bundle for sync_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding environment.
interface sync_fifo_ctrl_if #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CW-1:0]     count;
    logic              prog_full;
    logic              ram_wr_en;
    logic [AW-1:0]     ram_wr_addr;
    logic [DWIDTH-1:0] ram_wr_data;
    logic [AW-1:0]     ram_rd_addr;
    logic [DWIDTH-1:0] ram_rd_data;

    modport slave (
        input  s_data, s_valid, m_ready, ram_rd_data,
        output s_ready, m_data, m_valid, count, prog_full,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );

    modport master (
        output s_data, s_valid, m_ready, ram_rd_data,
        input  s_ready, m_data, m_valid, count, prog_full,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around an external dual-port RAM with an async read port.
// A one-word output register gives first-word-fall-through with registered m_data.
module sync_fifo_ctrl #(
    parameter int DWIDTH           = 64,
    parameter int DEPTH            = 16,
    parameter int PROG_FULL_THRESH = 12
) (
    input logic           clk,
    input logic           rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] PF_COUNT   = CW'(PROG_FULL_THRESH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       ram_entries;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_next;
    logic              m_valid_q;
    logic [DWIDTH-1:0] m_data_q;
    logic              prog_full_q;
    logic              s_ready_c;
    logic              wr_fire;
    logic              rd_fire;
    logic              load;

    always_comb begin
        ram_entries = wr_ptr - rd_ptr;
        s_ready_c   = (count_q < FULL_COUNT) && !rst;
        wr_fire     = bus.s_valid && s_ready_c;
        rd_fire     = m_valid_q && bus.m_ready;
        // The output register refills whenever it is empty or being drained this cycle.
        load        = (ram_entries != '0) && (!m_valid_q || bus.m_ready);
        count_next  = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            prog_full_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (load) begin
                m_data_q  <= bus.ram_rd_data;
                m_valid_q <= 1'b1;
                rd_ptr    <= rd_ptr + (AW+1)'(1);
            end else if (rd_fire) begin
                m_valid_q <= 1'b0;
            end
            count_q     <= count_next;
            // Evaluated on the next count so the flag lines up with count itself.
            prog_full_q <= (count_next >= PF_COUNT);
        end
    end

    assign bus.s_ready     = s_ready_c;
    assign bus.m_data      = m_data_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.count       = count_q;
    assign bus.prog_full   = prog_full_q;
    assign bus.ram_wr_en   = wr_fire;
    assign bus.ram_wr_addr = wr_ptr[AW-1:0];
    assign bus.ram_wr_data = bus.s_data;
    assign bus.ram_rd_addr = rd_ptr[AW-1:0];
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences an external simple dual-port RAM (one write port, one asynchronous read port) into a ready/valid stream FIFO. It owns the read and write pointers, occupancy count and full/empty decisions. It also owns a one-entry registered output stage that gives first-word-fall-through behaviour with a registered m_data. It sits between an upstream stream producer and a downstream consumer in the same clock domain, with the RAM instantiated alongside it.

Parameters:
DWIDTH, 64, data width of stream and RAM
DEPTH, 16, total FIFO capacity in words; power of 2, >= 2; also the RAM depth
PROG_FULL_THRESH, 12, prog_full asserts when count >= this value; range 1..DEPTH

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
s_data  in  DWIDTH  write data
s_valid  in  1  write request
s_ready  out  1  FIFO can accept a word
m_data  out  DWIDTH  read data (registered)
m_valid  out  1  m_data holds a valid word
m_ready  in  1  consumer accepts m_data
count  out  $clog2(DEPTH+1)  words held (RAM plus output register)
prog_full  out  1  registered threshold flag
ram_wr_en  out  1  RAM write enable
ram_wr_addr  out  $clog2(DEPTH)  RAM write address
ram_wr_data  out  DWIDTH  RAM write data
ram_rd_addr  out  $clog2(DEPTH)  RAM read address
ram_rd_data  in  DWIDTH  RAM async read data (combinational from ram_rd_addr)

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Pointers: wr_ptr and rd_ptr are AW+1 bits, where AW=$clog2(DEPTH). The MSB is the wrap bit. RAM entries held = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
- Reset: on any cycle with rst=1, the next edge sets wr_ptr=0, rd_ptr=0, count=0, m_valid=0, m_data=0, prog_full=0. While rst=1, s_ready=0 and ram_wr_en=0.
- Write handshake:
  - s_ready = (count < DEPTH) && !rst, decoded combinationally from registered state. It does not depend on m_ready.
  - wr_fire = s_valid && s_ready.
  - ram_wr_en = wr_fire; ram_wr_addr = wr_ptr[AW-1:0]; ram_wr_data = s_data.
  - wr_ptr increments by 1 at the edge where wr_fire=1, wrapping naturally.
- RAM read: ram_rd_addr = rd_ptr[AW-1:0] at all times.
- Output stage:
  - rd_fire = m_valid && m_ready.
  - load = (ram_entries != 0) && (!m_valid || m_ready).
  - On load: m_data <= ram_rd_data, m_valid <= 1, rd_ptr increments.
  - Else if rd_fire: m_valid <= 0.
  - m_data holds its value when not loading.
- No bypass: a word written into an empty FIFO reaches the RAM at edge N, loads into the output register at edge N+1, and m_valid is high in the cycle after that edge. Write-to-m_valid latency is 2 edges.
- count:
  - Increments on wr_fire only, decrements on rd_fire only, unchanged when both or neither occur.
  - Range 0..DEPTH. count == ram_entries + m_valid.
- Full: when count == DEPTH, s_ready=0 even if m_ready=1 that cycle. The freed slot is visible the next cycle. Overflow is impossible.
- Empty: m_valid=0 means nothing to read; m_ready is ignored and there is no underflow.
- prog_full is registered: prog_full <= (next count >= PROG_FULL_THRESH). It tracks count with the same timing and is not a cycle late relative to count.
- Back-to-back: with m_ready=1 held and a continuous writer, sustained throughput is 1 word/cycle in each direction.
- Reset mid-operation: all stored words are discarded. No pre-reset word ever appears on m_data after reset. RAM contents are not cleared; they are unreachable through the pointers.
- Stable-data rule: while m_valid=1 and m_ready=0, m_data and m_valid hold.

Test Plan:
- Reset: assert rst 2 cycles with s_valid=1 -> s_ready=0, ram_wr_en=0; after release m_valid=0, count=0, prog_full=0, m_data=0.
- Latency: write 0xA5 at cycle 0 with m_ready=1 -> ram_wr_en=1, ram_wr_addr=0 in cycle 0; m_valid=1, m_data=0xA5 in cycle 2; count 1 then 0 after the rd_fire edge.
- Fill: m_ready=0, write 16 words 0..15 back-to-back -> s_ready drops after the 16th handshake, count=16, prog_full=1 once count reaches 12; 17th s_valid is not accepted; m_ready=1 then drains 0..15 in order.
- Full with simultaneous read: at count=16, s_valid=1 and m_ready=1 -> only the read occurs, count=15; s_ready=1 next cycle.
- Wrap and backpressure: push 100 sequential words with random s_valid/m_ready -> output order is exact, pointers wrap at least 6 times, count is never > 16, and count == writes - reads each cycle.
- Reset mid-operation: at count=7 with m_valid=1, pulse rst one cycle -> next cycle count=0, m_valid=0; a new word 0x3C is the first and only word out.
